// File: rtl/div_seq_unit_if.sv
// Operand/result bundle between the control unit (master) and the divider (slave).
interface div_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/div_seq_unit.sv
// Sequential signed restoring divider: remainder to HI, quotient to LO, one quotient bit per cycle.
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  div_seq_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, SIGN, ZERO} state_t;

  state_t           r_state;
  logic             r_signPub;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_sgnDvd;
  logic             r_sgnDvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_divZero;

  logic [WIDTH:0]   w_remSh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_absDvd;
  logic [WIDTH-1:0] w_absDvs;

  // Trial subtraction is one bit wider so its MSB is the borrow (trial negative).
  always_comb begin
    w_remSh  = {r_rem, r_quo[WIDTH-1]};
    w_trial  = w_remSh - {1'b0, r_dvsr};
    w_absDvd = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    w_absDvs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_signPub <= 1'b0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
      r_sgnDvd  <= 1'b0;
      r_sgnDvs  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.divisor == '0) begin
              r_state <= ZERO;
            end else begin
              r_quo     <= w_absDvd;
              r_dvsr    <= w_absDvs;
              r_sgnDvd  <= bus.dividend[WIDTH-1];
              r_sgnDvs  <= bus.divisor[WIDTH-1];
              r_rem     <= '0;
              r_cnt     <= CW'(WIDTH - 1);
              r_signPub <= 1'b0;
              r_state   <= ITER;
            end
          end
        end
        ITER: begin
          r_rem <= w_trial[WIDTH] ? w_remSh[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state <= SIGN;
          end
        end
        // First SIGN cycle applies the signs in place; second publishes them with done.
        SIGN: begin
          if (!r_signPub) begin
            r_quo     <= (r_sgnDvd ^ r_sgnDvs) ? -r_quo : r_quo;
            r_rem     <= r_sgnDvd ? -r_rem : r_rem;
            r_signPub <= 1'b1;
          end else begin
            r_lo      <= r_quo;
            r_hi      <= r_rem;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_signPub <= 1'b0;
            r_state   <= IDLE;
          end
        end
        ZERO: begin
          r_done    <= 1'b1;
          r_divZero <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_divZero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: tb/tb_div_seq_unit.sv
// Directed self-checking bench for div_seq_unit with hand-computed quotients and remainders.
module tb_div_seq_unit;
  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  div_seq_unit_if #(.WIDTH(32)) bus ();

  div_seq_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      $error("[TB] check %s wrong", tag);
    end
  endtask

  // Start pulse is sampled at the posedge after the negedge drive; operands are then scrambled.
  task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 32'h1234_5678;
  endtask

  task automatic waitDone(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runDiv(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic [31:0] expLo, input logic [31:0] expHi,
                        input int expLat, input logic expZero);
    int lat;
    applyStimulus(dvd, dvs);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd1);
    waitDone(60, lat);
    checkOutput({tag, ".lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".lo"}, bus.lo, expLo);
    checkOutput({tag, ".hi"}, bus.hi, expHi);
    checkOutput({tag, ".divzero"}, 32'(bus.div_zero), 32'(expZero));
    checkOutput({tag, ".busyAtDone"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, ".donePulse"}, 32'(bus.done), 32'd0);
    checkOutput({tag, ".zeroPulse"}, 32'(bus.div_zero), 32'd0);
  endtask

  initial begin
    int  lat;
    bit  changed;
    bit  seenDone;
    checkCount   = 0;
    passCount    = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst.hi", bus.hi, 32'd0);
    checkOutput("rst.lo", bus.lo, 32'd0);
    checkOutput("rst.busy", 32'(bus.busy), 32'd0);
    checkOutput("rst.done", 32'(bus.done), 32'd0);
    checkOutput("rst.divzero", 32'(bus.div_zero), 32'd0);

    changed = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.div_zero !== 1'b0) changed = 1'b1;
    end
    checkOutput("idle.stable", 32'(changed), 32'd0);

    runDiv("d100by7", 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b0);
    runDiv("dm7by2", -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 1'b0);
    runDiv("d7bym2", 32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 34, 1'b0);
    runDiv("dm7bym2", -32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 34, 1'b0);
    runDiv("d9by4", 32'd9, 32'd4, 32'd2, 32'd1, 34, 1'b0);
    runDiv("d5by0", 32'd5, 32'd0, 32'd2, 32'd1, 1, 1'b1);
    runDiv("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 1'b0);
    runDiv("d3bymax", 32'd3, 32'h7FFF_FFFF, 32'd0, 32'd3, 34, 1'b0);
    runDiv("d0by5", 32'd0, 32'd5, 32'd0, 32'd0, 34, 1'b0);
    runDiv("dminby2", 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 34, 1'b0);

    // Second start mid-operation must not disturb the first result.
    applyStimulus(32'd1000, 32'd10);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("restart.busy", 32'(bus.busy), 32'd1);
    waitDone(60, lat);
    checkOutput("restart.lat", 32'(lat), 32'd24);
    checkOutput("restart.lo", bus.lo, 32'd100);
    checkOutput("restart.hi", bus.hi, 32'd0);
    @(posedge clk);
    #1;

    // Reset at N+15 aborts the operation and clears hi/lo.
    runDiv("preload", 32'd23, 32'd5, 32'd4, 32'd3, 34, 1'b0);
    applyStimulus(32'd77, 32'd6);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort.busy", 32'(bus.busy), 32'd0);
    checkOutput("abort.hi", bus.hi, 32'd0);
    checkOutput("abort.lo", bus.lo, 32'd0);
    seenDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seenDone = 1'b1;
    end
    checkOutput("abort.noDone", 32'(seenDone), 32'd0);

    runDiv("after", 32'd45, 32'd6, 32'd7, 32'd3, 34, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/div_seq_unit.md
Name: div_seq_unit

Overview:
Sequential signed 32-bit divider that feeds the HI/LO selection path of the multicycle datapath. It consumes the A/B operand registers on a one-cycle start pulse from the control unit. It produces the remainder for HI and the quotient for LO, with a done pulse and a divide-by-zero flag that the control unit uses for exception entry. It uses a restoring shift-subtract algorithm, one quotient bit per cycle.

Parameters:
WIDTH, 32, operand/result width in bits; the counter is sized $clog2(WIDTH).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  one-cycle request; sampled only in IDLE
dividend  input  WIDTH  signed dividend (A register)
divisor  input  WIDTH  signed divisor (B register)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
div_zero  output  1  one-cycle pulse, coincident with done, when divisor == 0
hi  output  WIDTH  remainder, registered
lo  output  WIDTH  quotient, registered

Behaviour:
- Reset (synchronous, active-high): state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. Reset has priority over every other event.
- Reset mid-operation: abort to IDLE, clear hi/lo, and raise no done pulse.
- States: IDLE -> ITER -> SIGN -> IDLE (normal path); IDLE -> ZERO -> IDLE (divisor == 0 path).
- IDLE:
  - On start with divisor == 0: go to ZERO.
  - On start with divisor != 0: latch |dividend| and |divisor| (two's-complement abs), latch both sign bits, clear the partial remainder, set counter=WIDTH-1, go to ITER.
  - Operands are sampled only at this edge; later input changes are ignored.
- ITER, one cycle per quotient bit, MSB first:
  - Shift {rem, q} left by 1.
  - Trial = rem_shifted - |divisor|, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem=trial and the q LSB=1; otherwise restore and the q LSB=0.
  - After the counter==0 iteration, go to SIGN. That is exactly WIDTH ITER cycles.
- SIGN:
  - lo = (sign_dividend XOR sign_divisor) ? -q : q.
  - hi = sign_dividend ? -rem : rem.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Pulse done=1 registered with hi/lo, then go to IDLE.
- ZERO: pulse done=1 and div_zero=1; hi/lo hold their previous values; go to IDLE.
- Latency, with start sampled at rising edge N:
  - Normal: hi/lo/done are visible after edge N+WIDTH+2 (N+34 for WIDTH=32); done deasserts at N+WIDTH+3.
  - Divide by zero: done/div_zero are visible after edge N+1 and deassert at N+2.
- busy is high in ITER, SIGN and ZERO and low in IDLE. It falls in the same cycle done is visible.
- start while busy is ignored; no queuing.
- A start in the cycle done is visible is also ignored, because the state is not yet IDLE. A new start is accepted from the cycle after done.
- Overflow case, dividend=-2^(WIDTH-1) and divisor=-1: the abs wraps, and the result is lo=0x80000000, hi=0. No flag is raised.
- Dividend=0: lo=0, hi=0 with normal latency.
- |dividend| < |divisor|: lo=0, hi=dividend.
- hi/lo change only at the SIGN edge (or at reset); they are stable at all other times.

Test Plan:
- Reset held 2 cycles then released -> hi=0, lo=0, busy=0, done=0, div_zero=0; idle with no start -> outputs unchanged for 50 cycles.
- start, 100 / 7 at edge N -> busy=1 from N+1; done=1 only in the cycle after N+34; lo=14, hi=2.
- Sign matrix:
  - -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 7/-2 -> lo=0xFFFFFFFD, hi=1.
  - -7/-2 -> lo=3, hi=0xFFFFFFFF.
- Preload hi/lo via 9/4 (lo=2, hi=1), then 5 / 0 -> done=div_zero=1 in the cycle after N+1 for one cycle; hi=1, lo=2 unchanged.
- 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. Then 3 / 0x7FFFFFFF -> lo=0, hi=3.
- Protocol checks:
  - Second start at N+10 with different operands -> ignored, result is from the first operands.
  - Reset asserted at N+15 -> busy=0, hi=lo=0, no done pulse in the following 40 cycles.
